// File: rtl/mmu_freelist_alloc.sv
// mmu_freelist_alloc: 4K-page allocator over a free-list RAM plus a page-ownership bitmap.
// Latency: the response write strobe comes 2 cycles after the request pop; at most 1 request per 2 cycles.
// Backpressure: a request is popped only while its response FIFO has room; rsp_full is sampled at grant only.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   init_done             free list initialised; requests are accepted from here on
//   alloc_fifo_empty/alloc_req_pop/alloc_req_id/alloc_req_size
//                         alloc request FIFO; data is valid the cycle after the pop
//   free_fifo_empty/free_req_pop/free_req_id/free_req_page_idx/free_req_size
//                         free request FIFO; data is valid the cycle after the pop
//   alloc_rsp_full/alloc_rsp_write_en/alloc_rsp_id/alloc_rsp_page_idx/alloc_rsp_fail/alloc_rsp_fail_reason
//                         alloc response FIFO write side
//   free_rsp_full/free_rsp_write_en/free_rsp_id/free_rsp_fail/free_rsp_fail_reason
//                         free response FIFO write side
// Optional: define MMU_ALLOC_STATS_EN to add stat_used_pages, stat_peak_used and stat_fail_cnt.
// Fail codes: 1 NO_SPACE, 2 BAD_SIZE, 3 BAD_INDEX, 4 DOUBLE_FREE.

module mmu_freelist_alloc #(
   parameter int PAGE_COUNT    = 4096,
   parameter int PAGE_IDX_W    = 12,
   parameter int SUB_W         = 3,
   parameter int ID_W          = 8,
   parameter int SIZE_W        = 4,
   parameter int MAX_SIZE_CODE = 3,
   parameter int FAIL_W        = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic                        init_done,
   input  logic                        alloc_fifo_empty,
   output logic                        alloc_req_pop,
   input  logic [ID_W-1:0]             alloc_req_id,
   input  logic [SIZE_W-1:0]           alloc_req_size,
   input  logic                        free_fifo_empty,
   output logic                        free_req_pop,
   input  logic [ID_W-1:0]             free_req_id,
   input  logic [PAGE_IDX_W+SUB_W-1:0] free_req_page_idx,
   input  logic [SIZE_W-1:0]           free_req_size,
   input  logic                        alloc_rsp_full,
   output logic                        alloc_rsp_write_en,
   output logic [ID_W-1:0]             alloc_rsp_id,
   output logic [PAGE_IDX_W+SUB_W-1:0] alloc_rsp_page_idx,
   output logic                        alloc_rsp_fail,
   output logic [FAIL_W-1:0]           alloc_rsp_fail_reason,
   input  logic                        free_rsp_full,
   output logic                        free_rsp_write_en,
   output logic [ID_W-1:0]             free_rsp_id,
   output logic                        free_rsp_fail,
   output logic [FAIL_W-1:0]           free_rsp_fail_reason
`ifdef MMU_ALLOC_STATS_EN
   ,
   output logic [PAGE_IDX_W:0]         stat_used_pages,
   output logic [PAGE_IDX_W:0]         stat_peak_used,
   output logic [15:0]                 stat_fail_cnt
`endif
);

   localparam int ADDR_W = PAGE_IDX_W + SUB_W;
   localparam int CNT_W  = PAGE_IDX_W + 1;

   localparam logic [SIZE_W-1:0]     MAX_SIZE = SIZE_W'(MAX_SIZE_CODE);
   localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(PAGE_COUNT);
   localparam logic [PAGE_IDX_W-1:0] LAST_IDX = PAGE_IDX_W'(PAGE_COUNT - 1);

   localparam logic [FAIL_W-1:0] FAIL_NO_SPACE    = FAIL_W'(1);
   localparam logic [FAIL_W-1:0] FAIL_BAD_SIZE    = FAIL_W'(2);
   localparam logic [FAIL_W-1:0] FAIL_BAD_INDEX   = FAIL_W'(3);
   localparam logic [FAIL_W-1:0] FAIL_DOUBLE_FREE = FAIL_W'(4);

   localparam logic RR_ALLOC = 1'b0;
   localparam logic RR_FREE  = 1'b1;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ALLOC, ST_FREE} state_t;

   state_t                  state_q, state_d;
   logic [PAGE_IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PAGE_IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]        free_cnt_q, free_cnt_d;
   logic [PAGE_COUNT-1:0]   bitmap_q, bitmap_d;
   logic                    rr_last_q, rr_last_d;
   logic                    init_done_q, init_done_d;

   logic                    alloc_rsp_write_en_q, alloc_rsp_write_en_d;
   logic [ID_W-1:0]         alloc_rsp_id_q, alloc_rsp_id_d;
   logic [ADDR_W-1:0]       alloc_rsp_page_idx_q, alloc_rsp_page_idx_d;
   logic                    alloc_rsp_fail_q, alloc_rsp_fail_d;
   logic [FAIL_W-1:0]       alloc_rsp_fail_reason_q, alloc_rsp_fail_reason_d;
   logic                    free_rsp_write_en_q, free_rsp_write_en_d;
   logic [ID_W-1:0]         free_rsp_id_q, free_rsp_id_d;
   logic                    free_rsp_fail_q, free_rsp_fail_d;
   logic [FAIL_W-1:0]       free_rsp_fail_reason_q, free_rsp_fail_reason_d;

   // Free-list storage: a circular queue of page indices, read at rd_ptr, written at wr_ptr.
   logic [PAGE_IDX_W-1:0]   fl_ram [PAGE_COUNT];
   logic [PAGE_IDX_W-1:0]   head_q;
   logic                    ram_we;
   logic [PAGE_IDX_W-1:0]   ram_waddr;
   logic [PAGE_IDX_W-1:0]   ram_wdata;

   logic                    alloc_elig;
   logic                    free_elig;
   logic [PAGE_IDX_W-1:0]   free_page;
   logic [SUB_W-1:0]        free_sub;

   assign alloc_elig = !alloc_fifo_empty && !alloc_rsp_full;
   assign free_elig  = !free_fifo_empty && !free_rsp_full;
   assign free_page  = free_req_page_idx[ADDR_W-1:SUB_W];
   assign free_sub   = free_req_page_idx[SUB_W-1:0];

   // Registered read: the head is always one cycle behind rd_ptr. rd_ptr only moves at the end
   // of an ALLOC cycle and the next ALLOC is at least two cycles later, so head_q is valid in time.
   // A free writing the slot under rd_ptr (empty list) is likewise visible by the next ALLOC.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         fl_ram[ram_waddr] <= ram_wdata;
      end
      head_q <= fl_ram[rd_ptr_q];
   end

   always_comb begin
      state_d                 = state_q;
      rd_ptr_d                = rd_ptr_q;
      wr_ptr_d                = wr_ptr_q;
      free_cnt_d              = free_cnt_q;
      bitmap_d                = bitmap_q;
      rr_last_d               = rr_last_q;
      init_done_d             = init_done_q;
      alloc_req_pop           = 1'b0;
      free_req_pop            = 1'b0;
      ram_we                  = 1'b0;
      ram_waddr               = wr_ptr_q;
      ram_wdata               = '0;
      // Response fields default to zero so they read as zero whenever write_en is low.
      alloc_rsp_write_en_d    = 1'b0;
      alloc_rsp_id_d          = '0;
      alloc_rsp_page_idx_d    = '0;
      alloc_rsp_fail_d        = 1'b0;
      alloc_rsp_fail_reason_d = '0;
      free_rsp_write_en_d     = 1'b0;
      free_rsp_id_d           = '0;
      free_rsp_fail_d         = 1'b0;
      free_rsp_fail_reason_d  = '0;

      case (state_q)
         ST_INIT: begin
            // wr_ptr doubles as the init counter and wraps back to 0 on the last entry.
            ram_we    = 1'b1;
            ram_wdata = wr_ptr_q;
            wr_ptr_d  = wr_ptr_q + PAGE_IDX_W'(1);
            if (wr_ptr_q == LAST_IDX) begin
               free_cnt_d  = FULL_CNT;
               init_done_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end

         ST_IDLE: begin
            // Round-robin: on contention grant the side that did not win last time.
            if (alloc_elig && (!free_elig || rr_last_q == RR_FREE)) begin
               alloc_req_pop = 1'b1;
               rr_last_d     = RR_ALLOC;
               state_d       = ST_ALLOC;
            end else if (free_elig) begin
               free_req_pop = 1'b1;
               rr_last_d    = RR_FREE;
               state_d      = ST_FREE;
            end
         end

         ST_ALLOC: begin
            alloc_rsp_write_en_d = 1'b1;
            alloc_rsp_id_d       = alloc_req_id;
            if (alloc_req_size > MAX_SIZE) begin
               alloc_rsp_fail_d        = 1'b1;
               alloc_rsp_fail_reason_d = FAIL_BAD_SIZE;
            end else if (free_cnt_q == '0) begin
               alloc_rsp_fail_d        = 1'b1;
               alloc_rsp_fail_reason_d = FAIL_NO_SPACE;
            end else begin
               alloc_rsp_page_idx_d = {head_q, {SUB_W{1'b0}}};
               rd_ptr_d             = rd_ptr_q + PAGE_IDX_W'(1);
               free_cnt_d           = free_cnt_q - CNT_W'(1);
               bitmap_d[head_q]     = 1'b1;
            end
            state_d = ST_IDLE;
         end

         ST_FREE: begin
            free_rsp_write_en_d = 1'b1;
            free_rsp_id_d       = free_req_id;
            if (free_req_size > MAX_SIZE) begin
               free_rsp_fail_d        = 1'b1;
               free_rsp_fail_reason_d = FAIL_BAD_SIZE;
            end else if (free_sub != '0) begin
               free_rsp_fail_d        = 1'b1;
               free_rsp_fail_reason_d = FAIL_BAD_INDEX;
            end else if (!bitmap_q[free_page]) begin
               // Also keeps free_cnt from ever exceeding PAGE_COUNT.
               free_rsp_fail_d        = 1'b1;
               free_rsp_fail_reason_d = FAIL_DOUBLE_FREE;
            end else begin
               ram_we              = 1'b1;
               ram_wdata           = free_page;
               wr_ptr_d            = wr_ptr_q + PAGE_IDX_W'(1);
               free_cnt_d          = free_cnt_q + CNT_W'(1);
               bitmap_d[free_page] = 1'b0;
            end
            state_d = ST_IDLE;
         end

         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q                 <= ST_INIT;
         rd_ptr_q                <= '0;
         wr_ptr_q                <= '0;
         free_cnt_q              <= '0;
         bitmap_q                <= '0;
         rr_last_q               <= RR_FREE;
         init_done_q             <= 1'b0;
         alloc_rsp_write_en_q    <= 1'b0;
         alloc_rsp_id_q          <= '0;
         alloc_rsp_page_idx_q    <= '0;
         alloc_rsp_fail_q        <= 1'b0;
         alloc_rsp_fail_reason_q <= '0;
         free_rsp_write_en_q     <= 1'b0;
         free_rsp_id_q           <= '0;
         free_rsp_fail_q         <= 1'b0;
         free_rsp_fail_reason_q  <= '0;
      end else begin
         state_q                 <= state_d;
         rd_ptr_q                <= rd_ptr_d;
         wr_ptr_q                <= wr_ptr_d;
         free_cnt_q              <= free_cnt_d;
         bitmap_q                <= bitmap_d;
         rr_last_q               <= rr_last_d;
         init_done_q             <= init_done_d;
         alloc_rsp_write_en_q    <= alloc_rsp_write_en_d;
         alloc_rsp_id_q          <= alloc_rsp_id_d;
         alloc_rsp_page_idx_q    <= alloc_rsp_page_idx_d;
         alloc_rsp_fail_q        <= alloc_rsp_fail_d;
         alloc_rsp_fail_reason_q <= alloc_rsp_fail_reason_d;
         free_rsp_write_en_q     <= free_rsp_write_en_d;
         free_rsp_id_q           <= free_rsp_id_d;
         free_rsp_fail_q         <= free_rsp_fail_d;
         free_rsp_fail_reason_q  <= free_rsp_fail_reason_d;
      end
   end

   assign init_done             = init_done_q;
   assign alloc_rsp_write_en    = alloc_rsp_write_en_q;
   assign alloc_rsp_id          = alloc_rsp_id_q;
   assign alloc_rsp_page_idx    = alloc_rsp_page_idx_q;
   assign alloc_rsp_fail        = alloc_rsp_fail_q;
   assign alloc_rsp_fail_reason = alloc_rsp_fail_reason_q;
   assign free_rsp_write_en     = free_rsp_write_en_q;
   assign free_rsp_id           = free_rsp_id_q;
   assign free_rsp_fail         = free_rsp_fail_q;
   assign free_rsp_fail_reason  = free_rsp_fail_reason_q;

`ifdef MMU_ALLOC_STATS_EN
   logic [CNT_W-1:0] stat_used_q, stat_used_d;
   logic [CNT_W-1:0] stat_peak_q, stat_peak_d;
   logic [15:0]      stat_fail_q, stat_fail_d;

   // Stats are computed from next-state values so they land on the same edge as the response.
   always_comb begin
      stat_used_d = stat_used_q;
      stat_peak_d = stat_peak_q;
      stat_fail_d = stat_fail_q;
      if (alloc_rsp_write_en_d || free_rsp_write_en_d) begin
         stat_used_d = FULL_CNT - free_cnt_d;
         if (stat_used_d > stat_peak_q) begin
            stat_peak_d = stat_used_d;
         end
         if ((alloc_rsp_fail_d || free_rsp_fail_d) && stat_fail_q != 16'hFFFF) begin
            stat_fail_d = stat_fail_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_used_q <= '0;
         stat_peak_q <= '0;
         stat_fail_q <= '0;
      end else begin
         stat_used_q <= stat_used_d;
         stat_peak_q <= stat_peak_d;
         stat_fail_q <= stat_fail_d;
      end
   end

   assign stat_used_pages = stat_used_q;
   assign stat_peak_used  = stat_peak_q;
   assign stat_fail_cnt   = stat_fail_q;
`endif

endmodule

// File: tb/tb_mmu_freelist_alloc.sv
// tb_mmu_freelist_alloc: scoreboard bench for the page allocator at PAGE_COUNT=16.
// Latency: expected responses are queued at pop time and compared when write_en is seen.
// Backpressure: response-full inputs are driven by the bench to exercise grant gating.

module tb_mmu_freelist_alloc;

   localparam int PC = 16;
   localparam int PW = 4;
   localparam int SW = 3;
   localparam int IW = 8;
   localparam int ZW = 4;
   localparam int FW = 3;
   localparam int AW = PW + SW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          init_done;
   logic          alloc_fifo_empty;
   logic          alloc_req_pop;
   logic [IW-1:0] alloc_req_id;
   logic [ZW-1:0] alloc_req_size;
   logic          free_fifo_empty;
   logic          free_req_pop;
   logic [IW-1:0] free_req_id;
   logic [AW-1:0] free_req_page_idx;
   logic [ZW-1:0] free_req_size;
   logic          alloc_rsp_full;
   logic          alloc_rsp_write_en;
   logic [IW-1:0] alloc_rsp_id;
   logic [AW-1:0] alloc_rsp_page_idx;
   logic          alloc_rsp_fail;
   logic [FW-1:0] alloc_rsp_fail_reason;
   logic          free_rsp_full;
   logic          free_rsp_write_en;
   logic [IW-1:0] free_rsp_id;
   logic          free_rsp_fail;
   logic [FW-1:0] free_rsp_fail_reason;
`ifdef MMU_ALLOC_STATS_EN
   logic [PW:0]   stat_used_pages;
   logic [PW:0]   stat_peak_used;
   logic [15:0]   stat_fail_cnt;
`endif

   always #5 clk = ~clk;

   mmu_freelist_alloc #(
      .PAGE_COUNT(PC), .PAGE_IDX_W(PW), .SUB_W(SW), .ID_W(IW),
      .SIZE_W(ZW), .MAX_SIZE_CODE(3), .FAIL_W(FW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_done(init_done),
      .alloc_fifo_empty(alloc_fifo_empty), .alloc_req_pop(alloc_req_pop),
      .alloc_req_id(alloc_req_id), .alloc_req_size(alloc_req_size),
      .free_fifo_empty(free_fifo_empty), .free_req_pop(free_req_pop),
      .free_req_id(free_req_id), .free_req_page_idx(free_req_page_idx),
      .free_req_size(free_req_size),
      .alloc_rsp_full(alloc_rsp_full), .alloc_rsp_write_en(alloc_rsp_write_en),
      .alloc_rsp_id(alloc_rsp_id), .alloc_rsp_page_idx(alloc_rsp_page_idx),
      .alloc_rsp_fail(alloc_rsp_fail), .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
      .free_rsp_full(free_rsp_full), .free_rsp_write_en(free_rsp_write_en),
      .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail),
      .free_rsp_fail_reason(free_rsp_fail_reason)
`ifdef MMU_ALLOC_STATS_EN
      , .stat_used_pages(stat_used_pages), .stat_peak_used(stat_peak_used),
      .stat_fail_cnt(stat_fail_cnt)
`endif
   );

   typedef struct {
      logic [IW-1:0] id;
      logic [ZW-1:0] size;
      logic [AW-1:0] idx;
   } req_t;

   typedef struct {
      logic [IW-1:0] id;
      logic [AW-1:0] page;
      logic          fail;
      logic [FW-1:0] reason;
      int            cyc;
      int            used;
      int            peak;
      int            fails;
   } exp_t;

   req_t aq[$];
   req_t fq[$];
   exp_t ae[$];
   exp_t fe[$];
   int   mlist[$];
   bit   mbit[PC];
   int   mpeak  = 0;
   int   mfails = 0;
   int   pop_kind[$];
   int   pop_cyc[$];
   bit   a_full_force = 1'b0;
   bit   f_full_force = 1'b0;
   int   full_drop_cyc = -1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Request FIFOs, reference allocator and response monitor.
   initial begin : model
      req_t r;
      exp_t e;
      int   c;
      int   p;
      bit   ap;
      bit   fp;
      bit   prev_full;
      alloc_fifo_empty  = 1'b1;
      free_fifo_empty   = 1'b1;
      alloc_rsp_full    = 1'b0;
      free_rsp_full     = 1'b0;
      alloc_req_id      = '0;
      alloc_req_size    = '0;
      free_req_id       = '0;
      free_req_page_idx = '0;
      free_req_size     = '0;
      forever begin
         @(negedge clk);
         if (alloc_rsp_write_en) begin
            if (ae.size() == 0) begin
               chk("a_unexpected", alloc_rsp_write_en, 0);
            end else begin
               e = ae.pop_front();
               chk("a_id", alloc_rsp_id, e.id);
               chk("a_page", alloc_rsp_page_idx, e.page);
               chk("a_fail", alloc_rsp_fail, e.fail);
               chk("a_reason", alloc_rsp_fail_reason, e.reason);
               chk("a_latency", cyc - e.cyc, 2);
`ifdef MMU_ALLOC_STATS_EN
               chk("a_stat_used", stat_used_pages, e.used);
               chk("a_stat_peak", stat_peak_used, e.peak);
               chk("a_stat_fails", stat_fail_cnt, e.fails);
`endif
            end
         end else if (rst_n) begin
            chk("a_quiet", {alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason}, 0);
         end
         if (free_rsp_write_en) begin
            if (fe.size() == 0) begin
               chk("f_unexpected", free_rsp_write_en, 0);
            end else begin
               e = fe.pop_front();
               chk("f_id", free_rsp_id, e.id);
               chk("f_fail", free_rsp_fail, e.fail);
               chk("f_reason", free_rsp_fail_reason, e.reason);
               chk("f_latency", cyc - e.cyc, 2);
`ifdef MMU_ALLOC_STATS_EN
               chk("f_stat_used", stat_used_pages, e.used);
               chk("f_stat_fails", stat_fail_cnt, e.fails);
`endif
            end
         end else if (rst_n) begin
            chk("f_quiet", {free_rsp_id, free_rsp_fail, free_rsp_fail_reason}, 0);
         end
         if (!init_done) chk("pop_before_init", {alloc_req_pop, free_req_pop}, 0);
         if (alloc_rsp_full) chk("a_pop_while_full", alloc_req_pop, 0);
         if (free_rsp_full) chk("f_pop_while_full", free_req_pop, 0);
         ap = alloc_req_pop;
         fp = free_req_pop;
         c  = cyc;
         if (ap && fp) chk("dual_pop", {ap, fp}, 2'b10);
         if (ap) begin pop_kind.push_back(0); pop_cyc.push_back(c); end
         if (fp) begin pop_kind.push_back(1); pop_cyc.push_back(c); end

         @(posedge clk);
         cyc++;
         #1;
         if (ap && aq.size() != 0) begin
            r = aq.pop_front();
            alloc_req_id   = r.id;
            alloc_req_size = r.size;
            e = '{id: r.id, page: '0, fail: 1'b0, reason: '0, cyc: c, used: 0, peak: 0, fails: 0};
            if (r.size > 3) begin
               e.fail = 1'b1; e.reason = 3'd2;
            end else if (mlist.size() == 0) begin
               e.fail = 1'b1; e.reason = 3'd1;
            end else begin
               p = mlist.pop_front();
               mbit[p] = 1'b1;
               e.page = AW'(p * 8);
            end
            if (e.fail) mfails++;
            e.used = PC - mlist.size();
            if (e.used > mpeak) mpeak = e.used;
            e.peak  = mpeak;
            e.fails = mfails;
            ae.push_back(e);
         end
         if (fp && fq.size() != 0) begin
            r = fq.pop_front();
            free_req_id       = r.id;
            free_req_size     = r.size;
            free_req_page_idx = r.idx;
            p = int'(r.idx) / 8;
            e = '{id: r.id, page: '0, fail: 1'b0, reason: '0, cyc: c, used: 0, peak: 0, fails: 0};
            if (r.size > 3) begin
               e.fail = 1'b1; e.reason = 3'd2;
            end else if (r.idx % 8 != 0) begin
               e.fail = 1'b1; e.reason = 3'd3;
            end else if (!mbit[p]) begin
               e.fail = 1'b1; e.reason = 3'd4;
            end else begin
               mbit[p] = 1'b0;
               mlist.push_back(p);
            end
            if (e.fail) mfails++;
            e.used  = PC - mlist.size();
            e.peak  = mpeak;
            e.fails = mfails;
            fe.push_back(e);
         end
         alloc_fifo_empty = (aq.size() == 0);
         free_fifo_empty  = (fq.size() == 0);
         prev_full        = alloc_rsp_full;
         alloc_rsp_full   = a_full_force;
         free_rsp_full    = f_full_force;
         if (prev_full && !alloc_rsp_full) full_drop_cyc = cyc;
      end
   end

   task automatic push_alloc(input int id, input int size);
      req_t r;
      r.id = IW'(id); r.size = ZW'(size); r.idx = '0;
      aq.push_back(r);
   endtask

   task automatic push_free(input int id, input int size, input int idx);
      req_t r;
      r.id = IW'(id); r.size = ZW'(size); r.idx = AW'(idx);
      fq.push_back(r);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((aq.size() + fq.size() + ae.size() + fe.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, aq.size() + fq.size() + ae.size() + fe.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin : main
      int n;
      int first_a;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {init_done, alloc_req_pop, free_req_pop,
                            alloc_rsp_write_en, free_rsp_write_en, alloc_rsp_page_idx}, 0);
`ifdef MMU_ALLOC_STATS_EN
      chk("reset_stats", {stat_used_pages, stat_peak_used, stat_fail_cnt}, 0);
`endif
      for (int i = 0; i < PC; i++) mlist.push_back(i);

      // Init sequencer: init_done after exactly PAGE_COUNT clocks.
      rst_n = 1'b1;
      n = 0;
      while (!init_done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("init_cycles", n, PC);

      // Exhaust the list: 16 pages in order, the 17th fails NO_SPACE.
      @(negedge clk);
      for (int i = 0; i <= PC; i++) push_alloc(i, 3);
      drain("drain_fill", 400);

      // Double free, then reuse of the freed page after the list wraps.
      push_free(8'h20, 0, 8'h28);
      push_free(8'h21, 0, 8'h28);
      drain("drain_dfree", 100);
      push_alloc(8'h30, 3);
      drain("drain_realloc", 100);

      // Bad size on alloc, misaligned index on free.
      push_alloc(8'h31, 5);
      drain("drain_badsize", 100);
      push_free(8'h22, 0, 8'h2C);
      drain("drain_badidx", 100);

      // Contention: last grant was a free, so pops go alloc, free, alloc, ... every 2 cycles.
      pop_kind.delete();
      pop_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         push_alloc(8'h40 + i, 3);
         push_free(8'h50 + i, 1, i * 8);
      end
      drain("drain_rr", 200);
      chk("rr_pop_count", pop_kind.size(), 8);
      for (int i = 0; i < pop_kind.size(); i++) begin
         chk($sformatf("rr_kind%0d", i), pop_kind[i], i % 2);
         if (i > 0) chk($sformatf("rr_gap%0d", i), pop_cyc[i] - pop_cyc[i-1], 2);
      end

      // Alloc response FIFO full: only frees are served until it drains.
      a_full_force = 1'b1;
      repeat (2) @(negedge clk);
      pop_kind.delete();
      pop_cyc.delete();
      push_alloc(8'h60, 3);
      push_alloc(8'h61, 2);
      push_free(8'h70, 0, 8'h20);
      push_free(8'h71, 3, 8'h30);
      push_free(8'h72, 0, 8'h40);
      n = 0;
      while ((fq.size() + fe.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk("bp_alloc_held", aq.size(), 2);
      chk("bp_pop_count", pop_kind.size(), 3);
      for (int i = 0; i < pop_kind.size(); i++) chk($sformatf("bp_kind%0d", i), pop_kind[i], 1);
      a_full_force = 1'b0;
      drain("drain_bp", 100);
      first_a = -1;
      for (int i = 0; i < pop_kind.size(); i++) begin
         if (pop_kind[i] == 0 && first_a < 0) first_a = pop_cyc[i];
      end
      chk("bp_resume_cycle", first_a, full_drop_cyc);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
